// File: rtl/mux2_arbiter_pkg.sv
// rtl/mux2_arbiter_pkg.sv - shared state encoding, select codes and sizing helper
package mux2_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_GNT_A = 2'b01;
  localparam state_t ST_GNT_B = 2'b10;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Burst counter width; a single-transfer burst still needs one bit of storage
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/mux2_arbiter_mux2.sv
// rtl/mux2_arbiter_mux2.sv - parameterised 2:1 data multiplexer
module mux2 #(
  parameter int DW = 1
) (
  input  logic          sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - round-robin burst-limited arbiter driving a 2:1 mux channel
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int DW        = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic [DW-1:0] data_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [DW-1:0] data_b,
  output logic          ack_b,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          sel,
  output logic          busy
);

  localparam int            CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          last;
  logic          last_nxt;
  logic          sel_nxt;

  // State register: grant state, registered select, burst count and last winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= SEL_A;
      cnt   <= '0;
      last  <= SEL_B;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state logic; everything holds while the consumer stalls. In a grant
  // state with out_ready high, a present request means this cycle transfers.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    if (out_ready) begin
      case (state)
        ST_IDLE: begin
          if (req_a && (!req_b || last == SEL_B)) begin
            state_nxt = ST_GNT_A;
          end else if (req_b) begin
            state_nxt = ST_GNT_B;
          end
        end
        ST_GNT_A: begin
          if (!req_a || (cnt == CNT_LAST && req_b)) begin
            last_nxt  = SEL_A;
            cnt_nxt   = '0;
            state_nxt = req_b ? ST_GNT_B : ST_IDLE;
          end else begin
            cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
          end
        end
        ST_GNT_B: begin
          if (!req_b || (cnt == CNT_LAST && req_a)) begin
            last_nxt  = SEL_B;
            cnt_nxt   = '0;
            state_nxt = req_a ? ST_GNT_A : ST_IDLE;
          end else begin
            cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
    // Select follows the granted side and keeps its value through IDLE
    if (state_nxt == ST_GNT_A) begin
      sel_nxt = SEL_A;
    end else if (state_nxt == ST_GNT_B) begin
      sel_nxt = SEL_B;
    end else begin
      sel_nxt = sel;
    end
  end

  // Output decode from registered state only; no path from req to sel
  always_comb begin
    out_valid = (state == ST_GNT_A && req_a) || (state == ST_GNT_B && req_b);
    ack_a     = (state == ST_GNT_A) && req_a && out_ready;
    ack_b     = (state == ST_GNT_B) && req_b && out_ready;
    busy      = (state != ST_IDLE);
  end

  mux2 #(.DW(DW)) u_mux2 (
    .sel (sel),
    .a   (data_a),
    .b   (data_b),
    .y   (out_data)
  );

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - self-checking bench for mux2_arbiter
module tb_mux2_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a;
  logic          req_b;
  logic          out_ready;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic          ack_a;
  logic          ack_b;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          sel;
  logic          busy;

  always #5 clk = ~clk;

  mux2_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .data_a    (data_a),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .ack_b     (ack_b),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner 0 = none, 1 = A, 2 = B; run counts transfers in the current grant
  int   m_owner = 0;
  int   m_run   = 0;
  int   m_last  = 2;
  logic m_sel   = 1'b0;
  logic acked_a = 1'b0;
  logic acked_b = 1'b0;

  typedef struct {
    logic rst_n, ra, rb, rdy;
    logic ea, eb, esel, ebusy, evalid;
    logic [7:0] edata;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_update();
    int mine, other;
    if (!rst_n) begin
      m_owner = 0; m_run = 0; m_last = 2; m_sel = 1'b0;
    end else if (out_ready) begin
      if (m_owner == 0) begin
        if (req_a && (!req_b || m_last == 2)) m_owner = 1;
        else if (req_b) m_owner = 2;
      end else begin
        mine  = (m_owner == 1) ? int'(req_a) : int'(req_b);
        other = (m_owner == 1) ? int'(req_b) : int'(req_a);
        if (mine == 0) begin
          m_last  = m_owner;
          m_run   = 0;
          m_owner = (other != 0) ? 3 - m_owner : 0;
        end else begin
          m_run++;
          if (m_run % MB == 0 && other != 0) begin
            m_last  = m_owner;
            m_run   = 0;
            m_owner = 3 - m_owner;
          end
        end
      end
      if (m_owner == 1) m_sel = 1'b0;
      else if (m_owner == 2) m_sel = 1'b1;
    end
  endtask

  // Check all outputs against the model, then advance one clock; returns at the next negedge
  task automatic step(input string tag);
    logic e_valid, e_ack_a, e_ack_b, e_busy;
    logic [7:0] e_data;
    #1;
    e_valid = (m_owner == 1 && req_a) || (m_owner == 2 && req_b);
    e_ack_a = (m_owner == 1) && req_a && out_ready;
    e_ack_b = (m_owner == 2) && req_b && out_ready;
    e_busy  = (m_owner != 0);
    e_data  = m_sel ? data_b : data_a;
    chk({tag, ".valid"}, out_valid, e_valid);
    chk({tag, ".ack_a"}, ack_a, e_ack_a);
    chk({tag, ".ack_b"}, ack_b, e_ack_b);
    chk({tag, ".sel"},   sel, m_sel);
    chk({tag, ".busy"},  busy, e_busy);
    chk({tag, ".data"},  out_data, e_data);
    acked_a = e_ack_a;
    acked_b = e_ack_b;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic ea, input logic eb,
                            input logic esel, input logic ebusy, input logic [7:0] edata);
    #1;
    chk({name, ".ack_a"}, ack_a, ea);
    chk({name, ".ack_b"}, ack_b, eb);
    chk({name, ".sel"},   sel, esel);
    chk({name, ".busy"},  busy, ebusy);
    chk({name, ".data"},  out_data, edata);
  endtask

  function automatic vec_t mk(input logic r, input logic ra, input logic rb, input logic rdy,
                              input logic ea, input logic eb, input logic es, input logic ebz,
                              input logic ev, input logic [7:0] ed);
    vec_t v;
    v.rst_n = r; v.ra = ra; v.rb = rb; v.rdy = rdy;
    v.ea = ea; v.eb = eb; v.esel = es; v.ebusy = ebz; v.evalid = ev; v.edata = ed;
    return v;
  endfunction

  initial begin
    // Reset, then fairness AAAA BBBB AAAA, then release back to IDLE
    tbl[0]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 8'h11);
    tbl[1]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 8'h11);
    for (int i = 2; i < 6; i++)   tbl[i] = mk(1, 1, 1, 1, 1, 0, 0, 1, 1, 8'h11);
    for (int i = 6; i < 10; i++)  tbl[i] = mk(1, 1, 1, 1, 0, 1, 1, 1, 1, 8'h22);
    for (int i = 10; i < 14; i++) tbl[i] = mk(1, 1, 1, 1, 1, 0, 0, 1, 1, 8'h11);
    tbl[14] = mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 8'h22);
    tbl[15] = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 8'h22);

    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
    data_a = 8'h11; data_b = 8'h22;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      rst_n = tbl[i].rst_n; req_a = tbl[i].ra; req_b = tbl[i].rb; out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d.ack_a", i), ack_a, tbl[i].ea);
      chk($sformatf("tbl%0d.ack_b", i), ack_b, tbl[i].eb);
      chk($sformatf("tbl%0d.sel", i),   sel, tbl[i].esel);
      chk($sformatf("tbl%0d.busy", i),  busy, tbl[i].ebusy);
      chk($sformatf("tbl%0d.valid", i), out_valid, tbl[i].evalid);
      chk($sformatf("tbl%0d.data", i),  out_data, tbl[i].edata);
      step($sformatf("tblm%0d", i));
    end

    // Single requester: three A transfers starting one cycle after req_a rises
    req_a = 1'b1; data_a = 8'hA5; req_b = 1'b0;
    expect_out("single.idle", 0, 0, 1, 0, 8'h22);
    step("single0");
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("single.x%0d", i), 1, 0, 0, 1, 8'hA5);
      step("single");
    end
    req_a = 1'b0;
    step("single.rel");
    step("single.idle2");

    // Backpressure: two A transfers, stall five cycles, two more, then B
    req_a = 1'b1;
    step("bp.arb");
    req_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_out($sformatf("bp.pre%0d", i), 1, 0, 0, 1, 8'hA5);
      step("bp.pre");
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("bp.stall%0d", i), 0, 0, 0, 1, 8'hA5);
      step("bp.stall");
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_out($sformatf("bp.post%0d", i), 1, 0, 0, 1, 8'hA5);
      step("bp.post");
    end
    expect_out("bp.hand", 0, 1, 1, 1, 8'h22);
    step("bp.hand");
    req_a = 1'b0; req_b = 1'b0;
    step("bp.rel");
    step("bp.idle");

    // Early release: A drops after one transfer, B follows without extra delay
    req_a = 1'b1; req_b = 1'b1; data_b = 8'h3C;
    step("er.arb");
    expect_out("er.a1", 1, 0, 0, 1, 8'hA5);
    step("er.a1");
    req_a = 1'b0;
    step("er.drop");
    expect_out("er.b1", 0, 1, 1, 1, 8'h3C);
    step("er.b1");

    // Reset mid-burst in GNT_B after two transfers
    req_a = 1'b1;
    expect_out("rst.b2", 0, 1, 1, 1, 8'h3C);
    step("rst.b2");
    rst_n = 1'b0;
    step("rst.low");
    rst_n = 1'b1;
    expect_out("rst.idle", 0, 0, 0, 0, 8'hA5);
    step("rst.idle");
    expect_out("rst.first", 1, 0, 0, 1, 8'hA5);
    step("rst.first");

    // Randomised traffic under the model, requesters mostly honouring the hold rule
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      out_ready = ($urandom_range(0, 99) < 70);
      if (!req_a || acked_a) begin
        req_a  = ($urandom_range(0, 99) < 60);
        data_a = 8'($urandom);
      end else if ($urandom_range(0, 99) < 3) begin
        req_a = 1'b0;
      end
      if (!req_b || acked_b) begin
        req_b  = ($urandom_range(0, 99) < 60);
        data_b = 8'($urandom);
      end else if ($urandom_range(0, 99) < 3) begin
        req_b = 1'b0;
      end
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 multiplexed output channel between two requesters, A and B.
- Drives the mux select (sel) and runs a req/ack handshake towards each requester and a valid/ready handshake towards the downstream consumer.
- Limits consecutive transfers per requester so neither can starve the other.
- Sits directly in front of the 2:1 mux datapath and replaces a static sel input with sequenced control.

Parameters:
- DW, 1, data width of each requester's data and of out_data.
- MAX_BURST, 4, maximum consecutive transfers granted to one requester while the other is requesting. Legal range is 1 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_a  in  1  requester A has data; must stay high with data_a stable until ack_a (dropping it early is an abort).
- data_a  in  DW  requester A data.
- ack_a  out  1  A's word transferred this cycle.
- req_b  in  1  requester B has data (same rules as A).
- data_b  in  DW  requester B data.
- ack_b  out  1  B's word transferred this cycle.
- out_valid  out  1  out_data valid.
- out_data  out  DW  multiplexed data.
- out_ready  in  1  downstream accepts out_data.
- sel  out  1  mux select: 0 = A, 1 = B (registered).
- busy  out  1  a grant is active (state is not IDLE).

Behaviour:
- Reset: one clock, reset is synchronous and active-low. The clock is clk and the reset is rst_n. rst_n low at a rising edge gives: state=IDLE, sel=0, cnt=0, last=B (so A wins the first tie). Reset mid-burst aborts without completing the burst.
- Resulting output values after reset: out_valid=0, ack_a=0, ack_b=0, busy=0, out_data=data_a.
- States: IDLE, GNT_A, GNT_B. Two-bit encoding. sel=0 in GNT_A, sel=1 in GNT_B, and sel holds its last value in IDLE.
- Combinational outputs, decoded from registered state:
  - out_valid = (GNT_A & req_a) | (GNT_B & req_b)
  - ack_a = GNT_A & req_a & out_ready
  - ack_b = GNT_B & req_b & out_ready
  - out_data = sel ? data_b : data_a
  - busy = state != IDLE
  - There is no combinational path from req to sel.
- Transfer (xfer): a cycle in which out_valid & out_ready are both high.
- IDLE transitions:
  - req_a & (!req_b | last==B) -> GNT_A.
  - else req_b -> GNT_B.
  - else stay in IDLE.
  - Latency from req rising to the first possible ack is 1 cycle.
- GNT_A transitions (GNT_B is symmetric):
  - On xfer, cnt increments.
  - If !req_a, or (xfer & cnt==MAX_BURST-1 & req_b): set last=A, cnt=0, and go to GNT_B if req_b, else IDLE.
  - If xfer & cnt==MAX_BURST-1 & !req_b: cnt wraps to 0 and the grant to A continues.
- Handover has no bubble: the cycle after A's final ack, GNT_B is active and B may be acked if out_ready is high.
- Backpressure: while out_ready=0, state, cnt and sel are frozen and no acks are issued.
- Simultaneous requests with no history after reset go to A. Thereafter requesters alternate per burst.
- cnt width is max(1, clog2(MAX_BURST)). With MAX_BURST=1 and both requesters active, grants alternate on every transfer.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE=2'b00, ST_GNT_A=2'b01, ST_GNT_B=2'b10;
  - SEL_A=1'b0 and SEL_B=1'b1.
- One natural sub-module: mux2, parameterised by DW, instantiated for the out_data path (out_data = sel ? data_b : data_a).
- FSM and burst counter stay in mux2_arbiter.

Test Plan (bench uses DW=8, MAX_BURST=4):
- Reset: rst_n=0 for 2 edges with req_a=req_b=1 and out_ready=1 -> out_valid=0, acks=0, sel=0, busy=0 throughout. First edge after release -> GNT_A; next cycle out_data=data_a, ack_a=1.
- Single requester: req_a=1, data_a=8'hA5, out_ready=1 for 3 transfers -> out_valid=1, out_data=8'hA5, ack_a=1 on 3 cycles starting 1 cycle after req_a rises. sel=0 and ack_b=0 throughout.
- Fairness: req_a=req_b=1 continuously, out_ready=1 -> ack sequence AAAA BBBB AAAA. sel toggles after every 4th ack with no idle cycle; busy stays 1.
- Backpressure: in GNT_A after 2 transfers with req_b=1, out_ready=0 for 5 cycles -> no acks, sel=0 stays. After out_ready=1, exactly 2 more A acks, then B is granted.
- Early release: A drops req_a after 1 transfer while req_b=1 and data_b=8'h3C -> next cycle sel=1, out_data=8'h3C, ack_b=1.
- Reset mid-burst: rst_n=0 for 1 edge while in GNT_B after 2 transfers -> IDLE with sel=0. With both still requesting afterwards, A is granted first.
